// File: rtl/demux12_buf.sv
// Buffered 1-to-2 demultiplexer: each accepted word is steered into one of two FIFOs.
// Define DEMUX12_AUTO_EN for round-robin steering that ignores S1.
module demux12_buf #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         S1,
    input  logic [W-1:0] Y,
    input  logic         Y_VALID,
    output logic         Y_READY,
    output logic [W-1:0] D0,
    output logic         D0_VALID,
    input  logic         D0_READY,
    output logic [W-1:0] D1,
    output logic         D1_VALID,
    input  logic         D1_READY
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    logic [W-1:0]  mem_q    [2][DEPTH];
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] wr_ptr_d [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW-1:0] rd_ptr_d [2];
    logic [CW-1:0] cnt_q    [2];
    logic [CW-1:0] cnt_d    [2];
    logic [W-1:0]  dout     [2];

    logic       sel;
    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] sink_ready;

`ifdef DEMUX12_AUTO_EN
    logic tog_q;
    logic tog_d;
    logic unused_s1;

    assign unused_s1 = S1;
    assign sel       = tog_q;

    // Toggle advances only on an accepted word, so a full channel holds the input.
    always_comb begin
        tog_d = tog_q ^ (Y_VALID & Y_READY);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tog_q <= 1'b0;
        end else begin
            tog_q <= tog_d;
        end
    end
`else
    assign sel = S1;
`endif

    assign sink_ready = {D1_READY, D0_READY};
    assign Y_READY    = !full[sel];

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            full[c]     = (cnt_q[c] == FullCnt);
            empty[c]    = (cnt_q[c] == '0);
            push[c]     = Y_VALID && Y_READY && (sel == 1'(c));
            pop[c]      = !empty[c] && sink_ready[c];
            dout[c]     = empty[c] ? '0 : mem_q[c][rd_ptr_q[c]];
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            cnt_d[c]    = cnt_q[c];
            if (push[c]) begin
                wr_ptr_d[c] = wr_ptr_q[c] + PW'(1);
            end
            if (pop[c]) begin
                rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
            end
            unique case ({push[c], pop[c]})
                2'b10:   cnt_d[c] = cnt_q[c] + CW'(1);
                2'b01:   cnt_d[c] = cnt_q[c] - CW'(1);
                default: cnt_d[c] = cnt_q[c];
            endcase
        end
    end

    assign D0       = dout[0];
    assign D1       = dout[1];
    assign D0_VALID = !empty[0];
    assign D1_VALID = !empty[1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
        end
    end

    // Storage needs no reset: outputs are gated to zero while a channel is empty.
    always_ff @(posedge CLK) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c] && !RST) begin
                mem_q[c][wr_ptr_q[c]] <= Y;
            end
        end
    end

endmodule

// File: tb/tb_demux12_buf.sv
// Self-checking bench for demux12_buf: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_demux12_buf;

    localparam int DEPTH = 2;

    logic       CLK;
    logic       RST;
    logic       S1;
    logic [7:0] Y;
    logic       Y_VALID;
    logic       Y_READY;
    logic [7:0] D0;
    logic       D0_VALID;
    logic       D0_READY;
    logic [7:0] D1;
    logic       D1_VALID;
    logic       D1_READY;

    int total = 0;
    int bad   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         tog = 1'b0;

    demux12_buf #(.W(8), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .S1       (S1),
        .Y        (Y),
        .Y_VALID  (Y_VALID),
        .Y_READY  (Y_READY),
        .D0       (D0),
        .D0_VALID (D0_VALID),
        .D0_READY (D0_READY),
        .D1       (D1),
        .D1_VALID (D1_VALID),
        .D1_READY (D1_READY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic bit m_sel();
`ifdef DEMUX12_AUTO_EN
        return tog;
`else
        return S1;
`endif
    endfunction

    function automatic logic m_ready();
        int n;
        n = m_sel() ? q1.size() : q0.size();
        return n < DEPTH;
    endfunction

    function automatic logic [7:0] m_d0();
        return (q0.size() != 0) ? q0[0] : 8'h00;
    endfunction

    function automatic logic [7:0] m_d1();
        return (q1.size() != 0) ? q1[0] : 8'h00;
    endfunction

    // Advance one clock and apply the same transfer to the reference queues.
    task automatic tick();
        bit s, psh, p0, p1;
        logic [7:0] w;
        s   = m_sel();
        psh = Y_VALID && m_ready();
        p0  = (q0.size() != 0) && D0_READY;
        p1  = (q1.size() != 0) && D1_READY;
        w   = Y;
        @(posedge CLK);
        if (RST) begin
            q0.delete();
            q1.delete();
            tog = 1'b0;
        end else begin
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            if (psh) begin
                if (s) q1.push_back(w);
                else   q0.push_back(w);
                tog = ~tog;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; Y_VALID = 1'b1; Y = 8'hFF; S1 = 1'b0;
        D0_READY = 1'b0; D1_READY = 1'b0;
        tick();
        tick();
        RST = 1'b0; Y_VALID = 1'b0;
        @(negedge CLK);
        total += 5;
        if (D0_VALID !== 1'b0) begin bad++; $display("FAIL reset_d0_valid got=%0b want=0", D0_VALID); end
        if (D1_VALID !== 1'b0) begin bad++; $display("FAIL reset_d1_valid got=%0b want=0", D1_VALID); end
        if (D0 !== 8'h00) begin bad++; $display("FAIL reset_d0 got=%h want=00", D0); end
        if (D1 !== 8'h00) begin bad++; $display("FAIL reset_d1 got=%h want=00", D1); end
        if (Y_READY !== 1'b1) begin bad++; $display("FAIL reset_y_ready got=%0b want=1", Y_READY); end
        tick();
    endtask

    task automatic test_steering();
        D0_READY = 1'b1; D1_READY = 1'b1;
        S1 = 1'b0; Y = 8'hA5; Y_VALID = 1'b1;
        @(negedge CLK);
        total++;
        if (Y_READY !== 1'b1) begin bad++; $display("FAIL steer_ready got=%0b want=1", Y_READY); end
        tick();
        S1 = 1'b1; Y = 8'h3C;
        @(negedge CLK);
        total += 3;
        if (D0_VALID !== 1'b1) begin bad++; $display("FAIL steer_d0_valid got=%0b want=1", D0_VALID); end
        if (D0 !== 8'hA5) begin bad++; $display("FAIL steer_d0 got=%h want=a5", D0); end
        if (D1_VALID !== 1'b0) begin bad++; $display("FAIL steer_d1_early got=%0b want=0", D1_VALID); end
        tick();
        Y_VALID = 1'b0;
        @(negedge CLK);
        total += 3;
        if (D1_VALID !== 1'b1) begin bad++; $display("FAIL steer_d1_valid got=%0b want=1", D1_VALID); end
        if (D1 !== 8'h3C) begin bad++; $display("FAIL steer_d1 got=%h want=3c", D1); end
        if (D0_VALID !== 1'b0) begin bad++; $display("FAIL steer_d0_drained got=%0b want=0", D0_VALID); end
        tick();
    endtask

    task automatic test_full_stall();
        D0_READY = 1'b0; D1_READY = 1'b1; S1 = 1'b0; Y_VALID = 1'b1;
        Y = 8'h01; tick();
        Y = 8'h02; tick();
        Y_VALID = 1'b1; Y = 8'h03;
        for (int s = 0; s < 2; s++) begin
            S1 = 1'(s);
            #1;
            total++;
            if (Y_READY !== m_ready()) begin
                bad++; $display("FAIL stall_ready_s1_%0d got=%0b want=%0b", s, Y_READY, m_ready());
            end
        end
        Y_VALID = 1'b0; D0_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total += 2;
            if (D0_VALID !== (q0.size() != 0)) begin
                bad++; $display("FAIL stall_d0_valid_%0d got=%0b want=%0b", i, D0_VALID, q0.size() != 0);
            end
            if (D0 !== m_d0()) begin bad++; $display("FAIL stall_d0_%0d got=%h want=%h", i, D0, m_d0()); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        D1_READY = 1'b0; D0_READY = 1'b1; S1 = 1'b1; Y = 8'h50; Y_VALID = 1'b1;
        tick();
        D1_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Y_VALID = (i < 6);
            Y = 8'(8'h60 + i);
            @(negedge CLK);
            total += 3;
            if (D1_VALID !== (q1.size() != 0)) begin
                bad++; $display("FAIL b2b_d1_valid_%0d got=%0b want=%0b", i, D1_VALID, q1.size() != 0);
            end
            if (D1 !== m_d1()) begin bad++; $display("FAIL b2b_d1_%0d got=%h want=%h", i, D1, m_d1()); end
            if (Y_READY !== m_ready()) begin
                bad++; $display("FAIL b2b_ready_%0d got=%0b want=%0b", i, Y_READY, m_ready());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        D0_READY = 1'b0; D1_READY = 1'b0; Y_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            S1 = 1'(i);
            Y = 8'(8'h80 + i);
            tick();
        end
        for (int s = 0; s < 2; s++) begin
            S1 = 1'(s);
            #1;
            total++;
            if (Y_READY !== m_ready()) begin
                bad++; $display("FAIL full_ready_s1_%0d got=%0b want=%0b", s, Y_READY, m_ready());
            end
        end
        RST = 1'b1;
        tick();
        RST = 1'b0; Y_VALID = 1'b0; D0_READY = 1'b1; D1_READY = 1'b1;
        @(negedge CLK);
        total += 5;
        if (D0_VALID !== 1'b0) begin bad++; $display("FAIL midrst_d0_valid got=%0b want=0", D0_VALID); end
        if (D1_VALID !== 1'b0) begin bad++; $display("FAIL midrst_d1_valid got=%0b want=0", D1_VALID); end
        if (D0 !== 8'h00) begin bad++; $display("FAIL midrst_d0 got=%h want=00", D0); end
        if (D1 !== 8'h00) begin bad++; $display("FAIL midrst_d1 got=%h want=00", D1); end
        if (Y_READY !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0b want=1", Y_READY); end
        tick();
        @(negedge CLK);
        total++;
        if (D0_VALID !== 1'b0 || D1_VALID !== 1'b0) begin
            bad++; $display("FAIL midrst_leftover got=%0b%0b want=00", D1_VALID, D0_VALID);
        end
        tick();
    endtask

    task automatic test_auto_steer();
        logic [7:0] got0[$];
        logic [7:0] got1[$];
        logic [7:0] exp0[$];
        logic [7:0] exp1[$];
        int idx = 0;
        bit acc;
        RST = 1'b1; Y_VALID = 1'b0;
        tick();
        RST = 1'b0; D0_READY = 1'b1; D1_READY = 1'b1; S1 = 1'b1;
`ifdef DEMUX12_AUTO_EN
        exp0 = '{8'h10, 8'h12};
        exp1 = '{8'h11, 8'h13};
`else
        exp1 = '{8'h10, 8'h11, 8'h12, 8'h13};
`endif
        for (int cyc = 0; cyc < 20; cyc++) begin
            Y_VALID = (idx < 4);
            Y = 8'(8'h10 + idx);
            @(negedge CLK);
            if (D0_VALID === 1'b1) got0.push_back(D0);
            if (D1_VALID === 1'b1) got1.push_back(D1);
            acc = Y_VALID && (Y_READY === 1'b1);
            tick();
            if (acc) idx++;
        end
        total += 3;
        if (idx != 4) begin bad++; $display("FAIL auto_accepts got=%0d want=4", idx); end
        if (got0.size() != exp0.size()) begin
            bad++; $display("FAIL auto_d0_count got=%0d want=%0d", got0.size(), exp0.size());
        end
        if (got1.size() != exp1.size()) begin
            bad++; $display("FAIL auto_d1_count got=%0d want=%0d", got1.size(), exp1.size());
        end
        for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
            total++;
            if (got0[i] !== exp0[i]) begin bad++; $display("FAIL auto_d0_%0d got=%h want=%h", i, got0[i], exp0[i]); end
        end
        for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
            total++;
            if (got1[i] !== exp1[i]) begin bad++; $display("FAIL auto_d1_%0d got=%h want=%h", i, got1[i], exp1[i]); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            RST      = ($urandom_range(63) == 0);
            S1       = 1'($urandom_range(1));
            Y        = 8'($urandom);
            Y_VALID  = ($urandom_range(3) != 0);
            D0_READY = ($urandom_range(3) != 0) && (i % 50 > 10);
            D1_READY = ($urandom_range(3) != 0) && (i % 70 < 50);
            @(negedge CLK);
            total += 5;
            if (Y_READY !== m_ready()) begin
                bad++; $display("FAIL rnd_ready_%0d got=%0b want=%0b", i, Y_READY, m_ready());
            end
            if (D0_VALID !== (q0.size() != 0)) begin
                bad++; $display("FAIL rnd_d0_valid_%0d got=%0b want=%0b", i, D0_VALID, q0.size() != 0);
            end
            if (D1_VALID !== (q1.size() != 0)) begin
                bad++; $display("FAIL rnd_d1_valid_%0d got=%0b want=%0b", i, D1_VALID, q1.size() != 0);
            end
            if (D0 !== m_d0()) begin bad++; $display("FAIL rnd_d0_%0d got=%h want=%h", i, D0, m_d0()); end
            if (D1 !== m_d1()) begin bad++; $display("FAIL rnd_d1_%0d got=%h want=%h", i, D1, m_d1()); end
            tick();
        end
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; S1 = 1'b0; Y = 8'h00; Y_VALID = 1'b0;
        D0_READY = 1'b0; D1_READY = 1'b0;
        test_reset();
        test_steering();
        test_full_stall();
        test_back_to_back();
        test_reset_mid();
        test_auto_steer();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
